systolic_operand_feeder: RTL
============================

// Module: systolic_operand_feeder
// PURPOSE
// Operand sequencer directly upstream of the 3x3 systolic MAC array. Holds matrices A and B
// (3x3, DW-bit each), loaded through a word-write port. On start it clears the array
// accumulators, then streams row i of A onto dataa(i+1) and column j of B onto datab(j+1),
// one k-index per cycle, all six lanes in the same cycle (the array applies its own skew).
// It then drains the array pipeline and pulses done when all nine array outputs equal C = A x B.
// PARAMETERS
// DW          32  operand width; array inputs are DW bits, array results 2*DW bits
// CLR_CYCLES   4  cycles mac_clr is held with zero operands (flushes 3-deep array skew regs)
// DRAIN_CYCLES 4  zero-operand cycles after last k (3 skew stages + 1 MAC register)
// PORTS
// clk      in   1     clock, all state on rising edge
// rst      in   1     asynchronous active-high reset
// wr_en    in   1     write strobe for matrix storage
// wr_sel   in   1     0 = write A, 1 = write B
// wr_row   in   2     row index 0..2
// wr_col   in   2     column index 0..2
// wr_data  in   DW    element value
// start    in   1     begin one multiply (sampled in IDLE only)
// busy     out  1     high from the cycle after accepted start until the done cycle
// done     out  1     one-cycle pulse: array outputs now hold C
// mac_clr  out  1     drives the array's rst (clears MAC accumulators)
// dataa1..dataa3 out DW  A lanes: dataa(i+1) = A[i][k] during STREAM
// datab1..datab3 out DW  B lanes: datab(j+1) = B[k][j] during STREAM
// BEHAVIOUR
// - One clock, clk; rst asynchronous active-high. On rst: state IDLE, busy=0, done=0, mac_clr=0,
//   all dataa/datab = 0, k counter = 0, all 18 storage words = 0.
// - All outputs registered. Operand outputs are 0 in every state except STREAM.
// - Storage write: when wr_en && !busy, mem[wr_sel][wr_row][wr_col] <= wr_data next edge.
//   wr_row or wr_col = 3 -> write ignored. wr_en while busy -> ignored (matrices frozen in a run).
// - FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> IDLE.
//   IDLE: start=1 -> CLEAR. start while busy is ignored, not queued.
//   CLEAR: mac_clr=1, operands 0, CLR_CYCLES cycles -> STREAM with k=0.
//   STREAM: mac_clr=0, present k-slice, k=0,1,2 over exactly 3 cycles -> DRAIN.
//   DRAIN: operands 0 for DRAIN_CYCLES cycles -> IDLE with done=1 for that first IDLE cycle.
// - Timeline (start sampled at edge 0): CLEAR cycles 1..4, STREAM 5..7, DRAIN 8..11,
//   done=1 and busy=0 in cycle 12. busy=1 cycles 1..11.
// - start asserted in the done cycle is accepted (state is IDLE); next run begins cycle 13.
// - wr_en and start in same IDLE cycle: write lands, run uses the new value.
// - No arithmetic here; values pass through unmodified (no sign handling, no width change).
// - rst mid-run: immediate return to IDLE, outputs zeroed, no done pulse; stored matrices are
//   cleared. Array accumulators are NOT guaranteed clean until the next run's CLEAR.
// - mac_clr deasserts on the same edge the first k-slice appears (clean accumulate from k=0).
// TESTING
// 1 Reset: assert rst mid-STREAM -> same cycle all operands 0, busy=0, mac_clr=0; no done later.
// 2 Load A=[[1,2,3],[4,5,6],[7,8,9]], B=I, start -> cycle 5 dataa1..3=1,4,7 datab1..3=1,0,0;
//   cycle 7 dataa1..3=3,6,9 datab1..3=0,0,1; done cycle 12; with array attached out1..9 = 1..9.
// 3 Full timeline: check mac_clr=1 exactly cycles 1..4, busy 1..11, done only cycle 12.
// 4 wr_en during busy with A[0][0]=99 -> ignored; rerun with same B=I gives adder_out1=1.
// 5 start held high continuously -> runs back-to-back, done every 12 cycles, no overlap.
// 6 A all 0xFFFFFFFF, B all 2, wr_row=3 write attempt -> write dropped; each C element
//   0x5_FFFFFFFA (3*2*0xFFFFFFFF, 64-bit) from the array.

Source files
------------

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: holds A and B for the 3x3 MAC array and
// sequences clear, k-slice streaming and drain for one C = A x B run.
module systolic_operand_feeder #(
  parameter int DW           = 32,
  parameter int CLR_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [1:0]    wr_row,
  input  logic [1:0]    wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mac_clr,
  output logic [DW-1:0] dataa1,
  output logic [DW-1:0] dataa2,
  output logic [DW-1:0] dataa3,
  output logic [DW-1:0] datab1,
  output logic [DW-1:0] datab2,
  output logic [DW-1:0] datab3
);

  localparam int MAX_A = (CLR_CYCLES > DRAIN_CYCLES) ?
                         CLR_CYCLES : DRAIN_CYCLES;
  localparam int MAXC  = (MAX_A > 3) ? MAX_A : 3;
  localparam int CW    = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    k_n;

  logic [DW-1:0] mem [2][3][3];

  assign k_n = cnt_n[1:0];

  // Matrix storage; frozen while a run is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            mem[s][r][c] <= '0;
    end else if (wr_en && !busy &&
                 wr_row != 2'd3 && wr_col != 2'd3) begin
      mem[wr_sel][wr_row][wr_col] <= wr_data;
    end
  end

  // Next state and phase counter (cnt doubles as k in STREAM)
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        if (cnt == CW'(CLR_CYCLES - 1)) begin
          state_n = STREAM;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STREAM: begin
        if (cnt == CW'(2)) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == CW'(DRAIN_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Registered outputs are computed from the next state so that
  // mac_clr drops on the same edge the k=0 slice appears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mac_clr <= 1'b0;
      dataa1  <= '0;
      dataa2  <= '0;
      dataa3  <= '0;
      datab1  <= '0;
      datab2  <= '0;
      datab3  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      busy    <= (state_n != IDLE);
      done    <= (state == DRAIN) && (state_n == IDLE);
      mac_clr <= (state_n == CLEAR);
      if (state_n == STREAM) begin
        dataa1 <= mem[0][0][k_n];
        dataa2 <= mem[0][1][k_n];
        dataa3 <= mem[0][2][k_n];
        datab1 <= mem[1][k_n][0];
        datab2 <= mem[1][k_n][1];
        datab3 <= mem[1][k_n][2];
      end else begin
        dataa1 <= '0;
        dataa2 <= '0;
        dataa3 <= '0;
        datab1 <= '0;
        datab2 <= '0;
        datab3 <= '0;
      end
    end
  end

endmodule
